// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one trial-subtract step per clock, unsigned operands.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   rsh_c;
  logic [WIDTH:0]   t_c;
  logic [WIDTH-1:0] q_step_c;
  logic [WIDTH-1:0] r_step_c;
  logic             last_c;

  // One restoring step: shift in next dividend bit, trial-subtract, keep or restore.
  // The partial remainder always stays below the divisor, so WIDTH bits hold it.
  always_comb begin
    rsh_c    = {r_q, q_q[WIDTH-1]};
    t_c      = rsh_c - {1'b0, div_q};
    q_step_c = {q_q[WIDTH-2:0], ~t_c[WIDTH]};
    r_step_c = t_c[WIDTH] ? rsh_c[WIDTH-1:0] : t_c[WIDTH-1:0];
    last_c   = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          q_q   <= q_step_c;
          r_q   <= r_step_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= q_step_c;
            remainder_q <= r_step_c;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE gives back-to-back issue.
          if (start) begin
            div_q <= divisor;
            q_q   <= dividend;
            r_q   <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            if (divisor == '0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
